// File: rtl/multi_voice_wave_reader_pkg.sv
// Shared constants and helpers for the multi-voice wave reader.
// Play modes, FSM encodings and output saturation.
package wave_pkg;

  localparam logic [1:0] PLAY_FWD    = 2'b00;
  localparam logic [1:0] PLAY_DOUBLE = 2'b01;
  localparam logic [1:0] PLAY_REV    = 2'b10;
  localparam logic [1:0] PLAY_PAUSE  = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Clamp a signed value into a w-bit two's complement range.
  function automatic logic signed [31:0] saturate(
    input logic signed [31:0] x,
    input int                 w
  );
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/multi_voice_wave_reader_if.sv
// Control/sample bus of the multi-voice wave reader.
// master = note/tempo control side, slave = the reader.
interface multi_voice_wave_reader_if #(
  parameter int NUM_VOICES = 3,
  parameter int PHASE_W    = 22,
  parameter int DATA_W     = 16
);
  logic [NUM_VOICES*(PHASE_W-2)-1:0] step_size;
  logic [NUM_VOICES-1:0]             voice_en;
  logic [1:0]                        play_state;
  logic                              phase_clear;
  logic                              generate_next;
  logic                              busy;
  logic                              sample_ready;
  logic [DATA_W-1:0]                 sample;

  modport master (
    output step_size, voice_en, play_state,
    output phase_clear, generate_next,
    input  busy, sample_ready, sample
  );

  modport slave (
    input  step_size, voice_en, play_state,
    input  phase_clear, generate_next,
    output busy, sample_ready, sample
  );
endinterface

// File: rtl/multi_voice_wave_reader_lookup.sv
// Quarter-wave sine lookup: phase fold, ROM, signed attenuated out.
// One cycle from phase_i to val_o/valid_o.
module quarter_wave_lookup
  import wave_pkg::*;
#(
  parameter int PHASE_W     = 22,
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 16,
  parameter int ATTEN_SHIFT = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PHASE_W-1:0]       phase_i,
  input  logic                     en_i,
  output logic                     valid_o,
  output logic signed [DATA_W:0]   val_o
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int LSB_W = PHASE_W - 2 - ADDR_W;
  localparam logic [63:0] FULL = (64'd1 << (DATA_W - 1)) - 64'd1;

  // Parabolic quarter-sine: rises from ~0 to full scale at the top entry.
  function automatic logic [DATA_W-1:0] rom_word(input int i);
    logic [63:0] r;
    logic [63:0] n;
    r = 64'(i) + 64'd1;
    n = 64'(DEPTH);
    return DATA_W'((r * ((n << 1) - r) * FULL) / (n * n));
  endfunction

  logic [DATA_W-1:0] rom [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    assign rom[g] = rom_word(g);
  end

  logic [1:0]        quad;
  logic [ADDR_W-1:0] raw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W:0]   mag;

  assign quad = phase_i[PHASE_W-1 -: 2];
  assign raw  = phase_i[PHASE_W-3 -: ADDR_W];
  assign addr = quad[0] ? ~raw : raw;
  assign mag  = {1'b0, rom[addr] >> ATTEN_SHIFT};

  if (LSB_W > 0) begin : g_lsb
    logic unused_lsb;
    assign unused_lsb = ^phase_i[LSB_W-1:0];
  end

  logic                   valid_q;
  logic signed [DATA_W:0] val_q;

  // Registered ROM read with sign applied for the lower half-wave.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      val_q   <= '0;
    end else begin
      valid_q <= en_i;
      val_q   <= quad[1] ? $signed(-mag) : $signed(mag);
    end
  end

  assign valid_o = valid_q;
  assign val_o   = val_q;
endmodule

// File: rtl/multi_voice_wave_reader.sv
// Multi-voice sine reader: N phase accumulators sharing one ROM,
// summed and saturated into one sample per generate_next request.
module multi_voice_wave_reader
  import wave_pkg::*;
#(
  parameter int NUM_VOICES  = 3,
  parameter int PHASE_W     = 22,
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 16,
  parameter int ATTEN_SHIFT = 3
) (
  input  logic                       clk,
  input  logic                       reset_n,
  multi_voice_wave_reader_if.slave   bus
);
  localparam int SW    = PHASE_W - 2;
  localparam int VC_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int ACC_W = DATA_W + $clog2(NUM_VOICES) + 1;

  logic [1:0]                          state_q, state_d;
  logic [VC_W-1:0]                     vcnt_q, vcnt_d;
  logic [1:0]                          mode_q, mode_d;
  logic signed [ACC_W-1:0]             acc_q, acc_d;
  logic [NUM_VOICES-1:0][PHASE_W-1:0]  phase_q, phase_d;
  logic [DATA_W-1:0]                   sample_q, sample_d;
  logic                                ready_q, ready_d;

  logic [PHASE_W-1:0]     cur_phase;
  logic [SW-1:0]          cur_step;
  logic                   cur_en;
  logic [PHASE_W-1:0]     new_phase;
  logic                   lk_valid;
  logic signed [DATA_W:0] lk_val;
  logic signed [31:0]     sat_w;

  // Select the voice being issued this cycle.
  always_comb begin
    cur_phase = '0;
    cur_step  = '0;
    cur_en    = 1'b0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (vcnt_q == VC_W'(v)) begin
        cur_phase = phase_q[v];
        cur_step  = bus.step_size[v*SW +: SW];
        cur_en    = bus.voice_en[v];
      end
    end
  end

  // Advance the selected phase per the mode latched at acceptance.
  always_comb begin
    new_phase = cur_phase;
    unique case (mode_q)
      PLAY_FWD:    new_phase = cur_phase + PHASE_W'(cur_step);
      PLAY_DOUBLE: new_phase = cur_phase + PHASE_W'({cur_step, 1'b0});
      PLAY_REV:    new_phase = cur_phase - PHASE_W'(cur_step);
      PLAY_PAUSE:  new_phase = cur_phase;
    endcase
  end

  quarter_wave_lookup #(
    .PHASE_W     (PHASE_W),
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .ATTEN_SHIFT (ATTEN_SHIFT)
  ) u_lookup (
    .clk     (clk),
    .rst_n   (reset_n),
    .phase_i (new_phase),
    .en_i    ((state_q == ST_ISSUE) && cur_en),
    .valid_o (lk_valid),
    .val_o   (lk_val)
  );

  assign sat_w = saturate(32'(acc_q), DATA_W);

  // Request sequencing, phase write-back and accumulation.
  always_comb begin
    state_d  = state_q;
    vcnt_d   = vcnt_q;
    mode_d   = mode_q;
    acc_d    = acc_q;
    phase_d  = phase_q;
    sample_d = sample_q;
    ready_d  = 1'b0;
    if (lk_valid) acc_d = acc_q + ACC_W'(lk_val);
    unique case (state_q)
      ST_IDLE: begin
        if (bus.phase_clear) phase_d = '0;
        if (bus.generate_next) begin
          state_d = ST_ISSUE;
          vcnt_d  = '0;
          mode_d  = bus.play_state;
          acc_d   = '0;
        end
      end
      ST_ISSUE: begin
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (vcnt_q == VC_W'(v) && cur_en) phase_d[v] = new_phase;
        end
        if (vcnt_q == VC_W'(NUM_VOICES - 1)) state_d = ST_DRAIN;
        else vcnt_d = vcnt_q + 1'b1;
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE: begin
        state_d  = ST_IDLE;
        sample_d = DATA_W'(sat_w);
        ready_d  = 1'b1;
      end
    endcase
  end

  // State registers; async reset aborts any request in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      vcnt_q   <= '0;
      mode_q   <= PLAY_FWD;
      acc_q    <= '0;
      phase_q  <= '0;
      sample_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      vcnt_q   <= vcnt_d;
      mode_q   <= mode_d;
      acc_q    <= acc_d;
      phase_q  <= phase_d;
      sample_q <= sample_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.sample_ready = ready_q;
  assign bus.sample       = sample_q;
endmodule

// File: tb/tb_multi_voice_wave_reader.sv
// Scoreboard bench for multi_voice_wave_reader.
// Two DUTs in lockstep: ATTEN_SHIFT=3 and ATTEN_SHIFT=0.
module tb_multi_voice_wave_reader;
  import wave_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [59:0] step;
  logic [2:0]  en;
  logic [1:0]  ps;
  logic        clr;
  logic        gen;

  multi_voice_wave_reader_if #(.NUM_VOICES(3), .PHASE_W(22), .DATA_W(16)) bus3 ();
  multi_voice_wave_reader_if #(.NUM_VOICES(3), .PHASE_W(22), .DATA_W(16)) bus0 ();

  assign bus3.step_size     = step;
  assign bus3.voice_en      = en;
  assign bus3.play_state    = ps;
  assign bus3.phase_clear   = clr;
  assign bus3.generate_next = gen;
  assign bus0.step_size     = step;
  assign bus0.voice_en      = en;
  assign bus0.play_state    = ps;
  assign bus0.phase_clear   = clr;
  assign bus0.generate_next = gen;

  multi_voice_wave_reader #(.ATTEN_SHIFT(3)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus3)
  );
  multi_voice_wave_reader #(.ATTEN_SHIFT(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Reference quarter-sine table: 32767 * x * (2 - x), x = (i+1)/1024.
  function automatic int rom_ref(input int i);
    longint r;
    r = longint'(i) + 1;
    return int'((r * (2048 - r) * 32767) / 1048576);
  endfunction

  function automatic int term(input logic [21:0] p, input int sh);
    logic [9:0] a;
    int m;
    a = p[19:10];
    if (p[20]) a = ~a;
    m = rom_ref(int'(a)) >>> sh;
    return p[21] ? -m : m;
  endfunction

  function automatic logic [15:0] sat16(input int x);
    if (x > 32767) return 16'h7FFF;
    if (x < -32768) return 16'h8000;
    return 16'(x);
  endfunction

  logic [21:0] mph [3];
  logic [15:0] q3 [$];
  logic [15:0] q0 [$];
  logic [15:0] last3;
  logic [15:0] last0;

  task automatic model_accept(input logic c);
    int s3;
    int s0;
    logic [21:0] st;
    s3 = 0;
    s0 = 0;
    if (c) mph = '{default: '0};
    for (int v = 0; v < 3; v++) begin
      if (en[v]) begin
        st = 22'(step[v*20 +: 20]);
        case (ps)
          PLAY_FWD:    mph[v] = mph[v] + st;
          PLAY_DOUBLE: mph[v] = mph[v] + st + st;
          PLAY_REV:    mph[v] = mph[v] - st;
          default:     mph[v] = mph[v];
        endcase
        s3 += term(mph[v], 3);
        s0 += term(mph[v], 0);
      end
    end
    q3.push_back(sat16(s3));
    q0.push_back(sat16(s0));
  endtask

  always @(negedge clk) begin
    if (reset_n && bus3.sample_ready) begin
      chk("sb3_has", 32'(q3.size() != 0), 1);
      if (q3.size() != 0) chk("sample3", bus3.sample, q3.pop_front());
      last3 = bus3.sample;
    end
    if (reset_n && bus0.sample_ready) begin
      chk("sb0_has", 32'(q0.size() != 0), 1);
      if (q0.size() != 0) chk("sample0", bus0.sample, q0.pop_front());
      last0 = bus0.sample;
    end
  end

  task automatic chk_ph(input string tag);
    for (int v = 0; v < 3; v++) begin
      chk(tag, dut.phase_q[v], mph[v]);
      chk(tag, dut0.phase_q[v], mph[v]);
    end
  endtask

  task automatic wait_ready();
    int lat;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (bus3.sample_ready) begin
        lat = i;
        break;
      end
    end
    chk("latency", lat, 5);
  endtask

  task automatic run_req(input logic [1:0] m, input logic [2:0] e,
                         input logic [59:0] s, input logic c);
    ps   = m;
    en   = e;
    step = s;
    clr  = c;
    gen  = 1'b1;
    @(posedge clk);
    model_accept(c);
    #1;
    gen = 1'b0;
    clr = 1'b0;
    chk("busy", bus3.busy, 1);
    wait_ready();
    @(posedge clk);
    #1;
    chk("pulse_w", bus3.sample_ready, 0);
  endtask

  task automatic reset_checks(input string tag);
    chk(tag, bus3.busy, 0);
    chk(tag, bus3.sample_ready, 0);
    chk(tag, bus3.sample, 0);
    chk(tag, bus0.sample, 0);
    mph = '{default: '0};
    chk_ph(tag);
  endtask

  task automatic count_pulses(input string tag, input int n,
                              input int want);
    int cnt;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (bus3.sample_ready) cnt++;
    end
    chk(tag, cnt, want);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  logic [59:0] s4;
  logic [15:0] first3;
  logic [15:0] e3;

  initial begin
    step  = '0;
    en    = '0;
    ps    = PLAY_FWD;
    clr   = 1'b0;
    gen   = 1'b0;
    last3 = '0;
    last0 = '0;
    mph   = '{default: '0};
    repeat (3) @(posedge clk);
    #1;
    reset_checks("rst_init");
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    run_req(PLAY_FWD, 3'b001, 60'h40000, 1'b0);
    chk("t2_ph0", dut.phase_q[0], 22'h040000);
    chk("t2_smp", last3, 32'(rom_ref(10'h100) >>> 3));
    chk_ph("t2_ph");

    run_req(PLAY_REV, 3'b001, 60'h40000, 1'b1);
    chk("t3_rev_ph0", dut.phase_q[0], 22'h3C0000);
    e3 = 16'(-(rom_ref(10'h0FF) >>> 3));
    chk("t3_rev_smp", last3, e3);
    run_req(PLAY_DOUBLE, 3'b001, 60'h40000, 1'b1);
    chk("t3_dbl_ph0", dut.phase_q[0], 22'h080000);

    s4 = {20'h0F0F1, 20'h2A5C3, 20'h1357B};
    run_req(PLAY_FWD, 3'b111, s4, 1'b1);
    first3 = last3;
    chk_ph("t4_ph");
    for (int k = 0; k < 4; k++) begin
      run_req(PLAY_PAUSE, 3'b111, s4, 1'b0);
      chk("t4_pause_same", last3, first3);
      chk_ph("t4_pause_ph");
    end
    run_req(PLAY_FWD, 3'b111, s4, 1'b1);
    chk("t4_clr_same", last3, first3);

    run_req(PLAY_FWD, 3'b111, {3{20'h0FFC00}}, 1'b1);
    chk("t5_pos_sat", last0, 16'h7FFF);
    chk("t5_pos_ph", dut0.phase_q[2], 22'h0FFC00);
    run_req(PLAY_DOUBLE, 3'b111, {3{20'h80000}}, 1'b0);
    run_req(PLAY_DOUBLE, 3'b111, {3{20'h80000}}, 1'b0);
    chk("t5_neg_ph", dut0.phase_q[1], 22'h2FFC00);
    chk("t5_neg_sat", last0, 16'h8000);

    ps   = PLAY_FWD;
    en   = 3'b111;
    step = {20'h01234, 20'h05678, 20'h09ABC};
    gen  = 1'b1;
    @(posedge clk);
    model_accept(1'b0);
    #1;
    gen = 1'b0;
    @(posedge clk);
    #1;
    gen = 1'b1;
    ps  = PLAY_PAUSE;
    @(posedge clk);
    #1;
    gen = 1'b0;
    count_pulses("t6_one_pulse", 12, 1);
    chk_ph("t6_latch_ph");

    ps  = PLAY_FWD;
    gen = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      model_accept(1'b0);
      #1;
      chk("t6_reaccept", bus3.busy, 1);
      wait_ready();
      if (k == 2) gen = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("t6_idle", bus3.busy, 0);
    chk_ph("t6_held_ph");

    reset_n = 1'b0;
    #1;
    reset_checks("rst_idle");
    #2;
    reset_n = 1'b1;
    count_pulses("rst_idle_nopulse", 8, 0);

    run_req(PLAY_FWD, 3'b111, s4, 1'b0);
    gen = 1'b1;
    @(posedge clk);
    model_accept(1'b0);
    #1;
    gen = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    q3.delete();
    q0.delete();
    #1;
    reset_checks("rst_issue");
    #2;
    reset_n = 1'b1;
    count_pulses("rst_issue_nopulse", 10, 0);

    chk("sb_drain", q3.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
